// File: rtl/f_truth_table_sequencer.sv
// f_truth_table_sequencer
// Walks the 4-bit input vector {a,b,c,d} through all 16 values, holds each
// one for SETTLE_CYCLES cycles, then samples the function block output f_in
// into table_out. Every sample is compared against a latched golden table.
// The result is reported as match, mismatch_count and first_fail.
module f_truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        match,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  // cnt counts 0 .. SETTLE_CYCLES-1 while a vector is settling
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [15:0] exp_q;
  logic        miss;

  assign miss = (f_in != exp_q[idx]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state selection; abort wins over everything while scanning
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETTLE;
      SETTLE: begin
        if (abort)                   next_state = IDLE;
        else if (cnt == SETTLE_LAST) next_state = SAMPLE;
      end
      SAMPLE: begin
        if (abort)             next_state = IDLE;
        else if (idx == 4'hF)  next_state = DONE;
        else                   next_state = SETTLE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Scan datapath: vector index, settle counter, captured table and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= '0;
      cnt            <= '0;
      exp_q          <= '0;
      table_out      <= '0;
      mismatch_count <= '0;
      first_fail     <= '0;
      match          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx            <= '0;
            cnt            <= '0;
            exp_q          <= expected;
            table_out      <= '0;
            mismatch_count <= '0;
            first_fail     <= '0;
            match          <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            idx <= '0;
            cnt <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            idx <= '0;
            cnt <= '0;
          end else begin
            table_out[idx] <= f_in;
            if (miss) begin
              mismatch_count <= mismatch_count + 5'd1;
              if (mismatch_count == 5'd0) first_fail <= idx;
            end
            if (idx == 4'hF) begin
              // Match is settled on entry to DONE so it is already valid while done pulses
              match <= (mismatch_count == 5'd0) && !miss;
            end else begin
              idx <= idx + 4'd1;
              cnt <= '0;
            end
          end
        end
        DONE: begin
          idx <= '0;
          cnt <= '0;
        end
        default: begin
          idx <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from state; the vector follows idx, which is zero whenever idle
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    {a, b, c, d} = idx;
    case (state)
      SETTLE:  busy = 1'b1;
      SAMPLE:  busy = 1'b1;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_f_truth_table_sequencer.sv
// tb_f_truth_table_sequencer
// Directed bench: one sequencer with SETTLE_CYCLES=1 driving a selectable
// function model, and a second one with SETTLE_CYCLES=3 driving ~(a^d).
module tb_f_truth_table_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] expected;
  logic        a, b, c, d, f_in;
  logic        busy, done, match;
  logic [15:0] table_out;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail;
  int          func_sel;

  logic        start3;
  logic [15:0] expected3;
  logic        a3, b3, c3, d3, f3;
  logic        busy3, done3, match3;
  logic [15:0] table_out3;
  logic [4:0]  mismatch_count3;
  logic [3:0]  first_fail3;

  int errors = 0;
  int checks = 0;

  f_truth_table_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .a(a), .b(b), .c(c), .d(d), .f_in(f_in), .busy(busy), .done(done),
    .table_out(table_out), .match(match), .mismatch_count(mismatch_count),
    .first_fail(first_fail)
  );

  f_truth_table_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .expected(expected3),
    .a(a3), .b(b3), .c(c3), .d(d3), .f_in(f3), .busy(busy3), .done(done3),
    .table_out(table_out3), .match(match3), .mismatch_count(mismatch_count3),
    .first_fail(first_fail3)
  );

  // Function blocks under test: 0 -> a&b, 1 -> constant 0, 2 -> ~(a^d)
  always_comb begin
    f_in = 1'b0;
    case (func_sel)
      0:       f_in = a & b;
      1:       f_in = 1'b0;
      default: f_in = ~(a ^ d);
    endcase
  end

  assign f3 = ~(a3 ^ d3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] exp_v);
    checks++;
    assert (observed === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, exp_v);
    end
  endtask

  // Called just after a falling edge; returns in cycle 1 after the accepting edge
  task automatic applyStimulus(input logic [15:0] exp_tbl, input int fsel);
    func_sel = fsel;
    expected = exp_tbl;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Steps falling edges until done is seen or the budget runs out
  task automatic waitDone(input int from, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int done_count;
    int first_done;
    int second_done;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = '0; func_sel = 0;
    start3 = 1'b0; expected3 = '0;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_vec", {a, b, c, d}, 0);
    checkOutput("reset_table", table_out, 0);
    checkOutput("reset_stats", {match, mismatch_count, first_fail}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // a&b against its own table
    applyStimulus(16'hF000, 0);
    checkOutput("t2_busy_c1", busy, 1);
    checkOutput("t2_vec_c1", {a, b, c, d}, 0);
    @(negedge clk); @(negedge clk);
    checkOutput("t2_vec_c3", {a, b, c, d}, 1);
    waitDone(3, cyc);
    checkOutput("t2_latency", cyc, 33);
    checkOutput("t2_busy_in_done", busy, 0);
    checkOutput("t2_vec_in_done", {a, b, c, d}, 15);
    checkOutput("t2_table", table_out, 16'hF000);
    checkOutput("t2_mcount", mismatch_count, 0);
    checkOutput("t2_match", match, 1);
    @(negedge clk);
    checkOutput("t2_done_pulse", done, 0);
    checkOutput("t2_match_hold", match, 1);
    checkOutput("t2_vec_idle", {a, b, c, d}, 0);

    // abort in cycle 10 (SAMPLE of idx 4): idx 0 and 2 captured, idx 4 suppressed
    applyStimulus(16'hF000, 2);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_vec", {a, b, c, d}, 0);
    checkOutput("t5_match", match, 0);
    checkOutput("t5_table", table_out, 16'h0005);
    checkOutput("t5_mcount", mismatch_count, 2);
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_count++;
      @(negedge clk);
    end
    checkOutput("t5_no_done", done_count, 0);
    checkOutput("t5_idle_busy", busy, 0);

    // constant 0 against a table with idx 4..7 set
    applyStimulus(16'h00F0, 1);
    checkOutput("t3_restart_busy", busy, 1);
    waitDone(1, cyc);
    checkOutput("t3_latency", cyc, 33);
    checkOutput("t3_table", table_out, 16'h0000);
    checkOutput("t3_mcount", mismatch_count, 4);
    checkOutput("t3_ffail", first_fail, 4);
    checkOutput("t3_match", match, 0);
    @(negedge clk);

    // start held high: one done per 34 cycles
    func_sel = 0;
    expected = 16'hF000;
    start = 1'b1;
    @(negedge clk);
    done_count = 0; first_done = 0; second_done = 0;
    for (int k = 1; k <= 101; k++) begin
      if (done === 1'b1) begin
        done_count++;
        if (done_count == 1) first_done = k;
        if (done_count == 2) second_done = k;
      end
      if (k < 101) @(negedge clk);
    end
    start = 1'b0;
    checkOutput("t6_done_count", done_count, 3);
    checkOutput("t6_first_done", first_done, 33);
    checkOutput("t6_period", second_done - first_done, 34);
    @(negedge clk); @(negedge clk);
    checkOutput("t6_stopped", busy, 0);

    // async reset mid-scan at idx 7
    applyStimulus(16'h0000, 2);
    repeat (14) @(negedge clk);
    checkOutput("t1_vec_before", {a, b, c, d}, 7);
    checkOutput("t1_table_before", table_out, 16'h0055);
    checkOutput("t1_mcount_before", mismatch_count, 4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_vec_async", {a, b, c, d}, 0);
    checkOutput("t1_busy_async", busy, 0);
    checkOutput("t1_table_async", table_out, 0);
    checkOutput("t1_mcount_async", mismatch_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t1_idle_after", {busy, done, a, b, c, d}, 0);

    // SETTLE_CYCLES=3 with ~(a^d): each vector held 4 cycles, done in cycle 65
    expected3 = 16'h0000;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    checkOutput("t4_busy_c1", busy3, 1);
    repeat (3) @(negedge clk);
    checkOutput("t4_vec_c4", {a3, b3, c3, d3}, 0);
    @(negedge clk);
    checkOutput("t4_vec_c5", {a3, b3, c3, d3}, 1);
    cyc = 5;
    while (done3 !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t4_latency", cyc, 65);
    checkOutput("t4_table", table_out3, 16'hAA55);
    checkOutput("t4_mcount", mismatch_count3, 8);
    checkOutput("t4_ffail", first_fail3, 0);
    checkOutput("t4_match", match3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
